layer_out_serializer: RTL and testbench

- Sits between two fully-connected layers. Consumes the parallel NN-neuron result vector of an upstream layer.
- Replays that vector as a serial stream of one value per cycle, matching the single-input (x_in/x_valid) format the next layer's neurons expect.
- Decouples layer timing: captures on the upstream completion strobe, then streams NN words back-to-back with a last-word marker.

---
 rtl/nn_pkg.sv | 12 +
 rtl/layer_out_serializer_vec_buf.sv | 41 ++++
 rtl/layer_out_serializer.sv | 162 ++++++++++++++++
 tb/tb_layer_out_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and default sizes for the fully-connected layer datapath.
package nn_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int NN_DEFAULT         = 10;
  localparam int DATA_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/layer_out_serializer_vec_buf.sv
// ser_vec_buf: NN-word vector register with load enable and an indexed word tap.
module ser_vec_buf
  import nn_pkg::*;
#(
  parameter int NN    = NN_DEFAULT,
  parameter int DW    = DATA_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(NN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [NN*DW-1:0]     i_vec,
  input  logic [CNT_W-1:0]     i_sel,
  output logic [DW-1:0]        o_word,
  output logic [NN*DW-1:0]     o_vec
);

  logic [NN*DW-1:0] r_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vec <= '0;
    end else if (i_load) begin
      r_vec <= i_vec;
    end
  end

  // Explicit compare-select so index codes >= NN read as zero instead of
  // falling off the end of the vector.
  always_comb begin
    o_word = '0;
    for (int k = 0; k < NN; k++) begin
      if (i_sel == CNT_W'(k)) begin
        o_word = r_vec[k*DW +: DW];
      end
    end
  end

  assign o_vec = r_vec;

endmodule

// File: rtl/layer_out_serializer.sv
// Captures an upstream layer's parallel result vector and replays it one word per cycle.
// Build option LAYER_SER_SKID_EN adds a one-deep pending vector for mid-stream captures.
module layer_out_serializer
  import nn_pkg::*;
#(
  parameter int NN        = NN_DEFAULT,
  parameter int dataWidth = DATA_WIDTH_DEFAULT,
  parameter int CNT_W     = $clog2(NN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_last,
  output logic                    busy,
  output logic                    overflow,
  input  logic                    overflow_clr
);

  ser_state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_idx, w_idx_nxt;
  logic                      r_ovf, w_ovf_nxt;
  logic [dataWidth-1:0]      r_data, w_data_nxt;
  logic                      w_strobe, w_at_last, w_shift_load, w_drop;
  logic [NN*dataWidth-1:0]   w_shift_vec;
  logic [dataWidth-1:0]      w_buf_word;
  logic [NN*dataWidth-1:0]   w_shift_vec_unused;
  logic                      w_valid_unused;

  // Upstream neurons finish in lockstep, so only bit 0 carries meaning.
  assign w_strobe       = i_valid[0];
  assign w_valid_unused = ^i_valid[NN-1:1];
  assign w_at_last      = (r_state == SER_SHIFT) && (r_idx == CNT_W'(NN - 1));

`ifdef LAYER_SER_SKID_EN
  logic                      r_pend, w_pend_nxt, w_pend_load, w_from_pend;
  logic [NN*dataWidth-1:0]   w_pend_vec;
  logic [dataWidth-1:0]      w_pend_word_unused;

  ser_vec_buf #(.NN(NN), .DW(dataWidth), .CNT_W(CNT_W)) u_pend_buf (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pend_load),
    .i_vec  (i_data),
    .i_sel  ('0),
    .o_word (w_pend_word_unused),
    .o_vec  (w_pend_vec)
  );

  assign w_shift_vec = w_from_pend ? w_pend_vec : i_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end
`else
  assign w_shift_vec = i_data;
`endif

  // Tap addressed with the next index so o_data can be registered.
  ser_vec_buf #(.NN(NN), .DW(dataWidth), .CNT_W(CNT_W)) u_shift_buf (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_shift_load),
    .i_vec  (w_shift_vec),
    .i_sel  (w_idx_nxt),
    .o_word (w_buf_word),
    .o_vec  (w_shift_vec_unused)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shift_load = 1'b0;
    w_drop       = 1'b0;
`ifdef LAYER_SER_SKID_EN
    w_from_pend  = 1'b0;
    w_pend_load  = 1'b0;
    w_pend_nxt   = r_pend;
`endif
    case (r_state)
      SER_IDLE: begin
        if (w_strobe) begin
          w_shift_load = 1'b1;
          w_idx_nxt    = '0;
          w_state_nxt  = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (w_at_last) begin
          w_idx_nxt = '0;
`ifdef LAYER_SER_SKID_EN
          if (r_pend) begin
            w_shift_load = 1'b1;
            w_from_pend  = 1'b1;
            w_pend_load  = w_strobe;
            w_pend_nxt   = w_strobe;
          end else
`endif
          if (w_strobe) begin
            w_shift_load = 1'b1;
          end else begin
            w_state_nxt = SER_IDLE;
          end
        end else begin
          w_idx_nxt = r_idx + CNT_W'(1);
          if (w_strobe) begin
`ifdef LAYER_SER_SKID_EN
            if (!r_pend) begin
              w_pend_load = 1'b1;
              w_pend_nxt  = 1'b1;
            end else begin
              w_drop = 1'b1;
            end
`else
            w_drop = 1'b1;
`endif
          end
        end
      end
      default: w_state_nxt = SER_IDLE;
    endcase
  end

  always_comb begin
    w_data_nxt = '0;
    if (w_shift_load) begin
      w_data_nxt = w_shift_vec[dataWidth-1:0];
    end else if (w_state_nxt == SER_SHIFT) begin
      w_data_nxt = w_buf_word;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  assign w_ovf_nxt = w_drop ? 1'b1 : (overflow_clr ? 1'b0 : r_ovf);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SER_IDLE;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ovf   <= w_ovf_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign o_valid  = (r_state == SER_SHIFT);
  assign busy     = (r_state == SER_SHIFT);
  assign o_last   = w_at_last;
  assign o_data   = r_data;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Self-checking bench for layer_out_serializer: directed table, corner sequences, random vs queue model.
module tb_layer_out_serializer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NN-1:0]     i_valid = '0;
  logic [NN*DW-1:0]  i_data = '0;
  logic              overflow_clr = 1'b0;
  logic              o_valid, o_last, busy, overflow;
  logic [DW-1:0]     o_data;

  always #5 clk = ~clk;

  layer_out_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_last       (o_last),
    .busy         (busy),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Model: queue of words still owed to the output, each tagged with its last-word flag.
  typedef struct {
    logic [DW-1:0] w;
    logic          last;
  } word_t;

  word_t q[$];
  logic  m_ovf = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    nvalid = 0;

  typedef struct {
    logic          stb;
    logic [DW-1:0] base;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          exp_l;
    logic          exp_b;
    logic          exp_o;
  } row_t;

  row_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NN*DW-1:0] seq_vec(input logic [DW-1:0] base);
    logic [NN*DW-1:0] v;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  function automatic logic [NN*DW-1:0] rand_vec();
    logic [NN*DW-1:0] v;
    logic [31:0] r;
    for (int k = 0; k < NN; k++) begin
      r = $urandom;
      v[k*DW +: DW] = r[DW-1:0];
    end
    return v;
  endfunction

  // Accepted when idle, on the last word of a vector, or (skid build) while no second vector is queued.
  function automatic bit model_accepts();
    if (q.size() == 0) return 1'b1;
    if (q[0].last) return 1'b1;
`ifdef LAYER_SER_SKID_EN
    return q.size() <= NN;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input logic stb, input logic [NN*DW-1:0] vec, input logic clr);
    bit acc;
    word_t e;
    acc = model_accepts();
    if (q.size() > 0) void'(q.pop_front());
    if (stb && acc) begin
      for (int k = 0; k < NN; k++) begin
        e.w = vec[k*DW +: DW];
        e.last = (k == NN - 1);
        q.push_back(e);
      end
    end
    if (stb && !acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic model_check();
    logic          ev, el;
    logic [DW-1:0] ed;
    ev = (q.size() > 0);
    ed = ev ? q[0].w : '0;
    el = ev ? q[0].last : 1'b0;
    check("model.o_valid", o_valid, ev);
    check("model.o_data", o_data, ed);
    check("model.o_last", o_last, el);
    check("model.busy", busy, ev);
    check("model.overflow", overflow, m_ovf);
  endtask

  // One clock: drive inputs, check against model mid-cycle, advance model, return at edge+1.
  task automatic cycle(input logic stb, input logic [NN*DW-1:0] vec, input logic clr);
    logic [31:0] r;
    r = $urandom;
    i_valid = r[NN-1:0];
    i_valid[0] = stb;
    i_data = vec;
    overflow_clr = clr;
    @(negedge clk);
    if (o_valid) nvalid++;
    model_check();
    model_step(stb, vec, clr);
    @(posedge clk);
    #1;
    i_valid = '0;
    overflow_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rand_vec(), 1'b0);
  endtask

  initial begin
    for (int r = 0; r < 11; r++) begin
      tbl[r].stb   = (r == 0);
      tbl[r].base  = 16'h0001;
      tbl[r].exp_v = (r < 10);
      tbl[r].exp_d = (r < 10) ? DW'(r + 1) : '0;
      tbl[r].exp_l = (r == 9);
      tbl[r].exp_b = (r < 10);
      tbl[r].exp_o = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset.o_valid", o_valid, 0);
    check("reset.o_data", o_data, 0);
    check("reset.o_last", o_last, 0);
    check("reset.busy", busy, 0);
    check("reset.overflow", overflow, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic stream 0x0001..0x000A
    for (int r = 0; r < 11; r++) begin
      cycle(tbl[r].stb, tbl[r].stb ? seq_vec(tbl[r].base) : rand_vec(), 1'b0);
      check($sformatf("tbl[%0d].o_valid", r), o_valid, tbl[r].exp_v);
      check($sformatf("tbl[%0d].o_data", r), o_data, tbl[r].exp_d);
      check($sformatf("tbl[%0d].o_last", r), o_last, tbl[r].exp_l);
      check($sformatf("tbl[%0d].busy", r), busy, tbl[r].exp_b);
      check($sformatf("tbl[%0d].overflow", r), overflow, tbl[r].exp_o);
    end

    // Second strobe in the o_last cycle
    nvalid = 0;
    cycle(1'b1, seq_vec(16'h0001), 1'b0);
    idle(9);
    cycle(1'b1, seq_vec(16'h0100), 1'b0);
    idle(12);
    check("b2b.valid_count", nvalid, 20);
    check("b2b.overflow", overflow, 0);

    // Strobe at index 3, third strobe at index 6
    nvalid = 0;
    cycle(1'b1, seq_vec(16'h0200), 1'b0);
    idle(3);
    cycle(1'b1, seq_vec(16'h0300), 1'b0);
`ifdef LAYER_SER_SKID_EN
    check("mid.overflow_after_idx3", overflow, 0);
`else
    check("mid.overflow_after_idx3", overflow, 1);
`endif
    idle(2);
    cycle(1'b1, seq_vec(16'h0400), 1'b0);
    check("mid.overflow_after_third", overflow, 1);
    idle(25);
`ifdef LAYER_SER_SKID_EN
    check("mid.valid_count", nvalid, 20);
`else
    check("mid.valid_count", nvalid, 10);
`endif

    // Overflow clear alone, then clear coincident with a drop
    cycle(1'b0, rand_vec(), 1'b1);
    check("clr.alone", overflow, 0);
    cycle(1'b1, seq_vec(16'h0500), 1'b0);
    idle(2);
`ifdef LAYER_SER_SKID_EN
    cycle(1'b1, seq_vec(16'h0600), 1'b0);
`endif
    cycle(1'b1, seq_vec(16'h0700), 1'b1);
    check("clr.vs_drop", overflow, 1);
    idle(25);

    // Async reset at index 5 with overflow set
    check("rst.overflow_before", overflow, 1);
    cycle(1'b1, seq_vec(16'h0800), 1'b0);
    idle(5);
    check("rst.o_data_idx5", o_data, 16'h0805);
    #2 rst = 1'b0;
    #1;
    check("rst.o_valid", o_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.overflow", overflow, 0);
    check("rst.o_last", o_last, 0);
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    cycle(1'b1, seq_vec(16'h0900), 1'b0);
    check("rst.restart_word0", o_data, 16'h0900);
    idle(11);

    // Random strobes and clears against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 5) == 0, rand_vec(), $urandom_range(0, 15) == 0);
    end
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
